// File: rtl/uart_bus_master.sv
// UART command bridge: turns 'W'/'R' byte frames into single-word device-bus accesses
// and streams the response ('K' for writes, 4 data bytes LSB first for reads) back out.
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o,
    output logic        devEnable_o,
    output logic        devWrite_o,
    input  logic        devBusy_i,
    output logic [31:0] devPhysicalAddr_o,
    output logic [31:0] devDataSave_o,
    input  logic [31:0] devDataLoad_i,
    output logic [3:0]  devByteSelect_o,
    output logic        active_o
);

    // state  | meaning
    // IDLE   | waiting for a command byte
    // ADDR   | collecting 4 address bytes, LSB first
    // DATA   | collecting 4 write-data bytes, LSB first
    // BUS    | device access in flight, held until devBusy_i=0
    // TX     | offering the next response byte to the transmitter
    // TXWAIT | letting the transmitter finish the byte just started
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADDR   = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] BUS    = 3'd3;
    localparam logic [2:0] TX     = 3'd4;
    localparam logic [2:0] TXWAIT = 3'd5;

    localparam logic [7:0] CMD_W  = 8'h57;
    localparam logic [7:0] CMD_R  = 8'h52;
    localparam logic [7:0] RSP_OK = 8'h4B;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic          cmd_write;
    logic [1:0]    byte_cnt;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rsp;
    logic [TW-1:0] tmo_cnt;
    logic          txwait_first;
    logic [7:0]    tx_byte;

    always_comb begin
        tx_byte = rsp[7:0];
        if (cmd_write) begin
            tx_byte = RSP_OK;
        end else begin
            case (byte_cnt)
                2'd0:    tx_byte = rsp[7:0];
                2'd1:    tx_byte = rsp[15:8];
                2'd2:    tx_byte = rsp[23:16];
                default: tx_byte = rsp[31:24];
            endcase
        end
    end

    // Bus and TX strobes decode straight from state so reset kills them asynchronously.
    assign txdStart_o        = (state == TX) && !txdBusy_i;
    assign txdData_o         = (state == TX) ? tx_byte : 8'h00;
    assign devEnable_o       = (state == BUS);
    assign devWrite_o        = (state == BUS) && cmd_write;
    assign devPhysicalAddr_o = addr;
    assign devDataSave_o     = wdata;
    assign devByteSelect_o   = 4'hf;
    assign active_o          = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cmd_write    <= 1'b0;
            byte_cnt     <= 2'd0;
            addr         <= 32'h0;
            wdata        <= 32'h0;
            rsp          <= 32'h0;
            tmo_cnt      <= '0;
            txwait_first <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rxdReady_i && (rxdData_i == CMD_W || rxdData_i == CMD_R)) begin
                        cmd_write <= (rxdData_i == CMD_W);
                        byte_cnt  <= 2'd0;
                        tmo_cnt   <= TMO_LOAD;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    // A byte landing on the terminal count still wins over the timeout.
                    if (rxdReady_i) begin
                        addr     <= {rxdData_i, addr[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        tmo_cnt  <= TMO_LOAD;
                        if (byte_cnt == 2'd3) begin
                            state <= cmd_write ? DATA : BUS;
                        end
                    end else if (tmo_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (rxdReady_i) begin
                        wdata    <= {rxdData_i, wdata[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        tmo_cnt  <= TMO_LOAD;
                        if (byte_cnt == 2'd3) begin
                            state <= BUS;
                        end
                    end else if (tmo_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                BUS: begin
                    if (!devBusy_i) begin
                        if (!cmd_write) begin
                            rsp <= devDataLoad_i;
                        end
                        byte_cnt <= 2'd0;
                        state    <= TX;
                    end
                end
                TX: begin
                    if (!txdBusy_i) begin
                        byte_cnt     <= byte_cnt + 2'd1;
                        txwait_first <= 1'b1;
                        state        <= TXWAIT;
                    end
                end
                TXWAIT: begin
                    // The transmitter may not raise busy until a cycle after the start strobe.
                    if (txwait_first) begin
                        txwait_first <= 1'b0;
                    end else if (!txdBusy_i) begin
                        state <= (!cmd_write && byte_cnt != 2'd0) ? TX : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: write, stalled read, bad command, timeout,
// reset mid-access and a stray byte during the response stream.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxdReady_i = 1'b0;
    logic [7:0]  rxdData_i = 8'h00;
    logic        txdBusy_i = 1'b0;
    logic        txdStart_o;
    logic [7:0]  txdData_o;
    logic        devEnable_o;
    logic        devWrite_o;
    logic        devBusy_i = 1'b0;
    logic [31:0] devPhysicalAddr_o;
    logic [31:0] devDataSave_o;
    logic [31:0] devDataLoad_i = 32'h0;
    logic [3:0]  devByteSelect_o;
    logic        active_o;

    uart_bus_master #(.TIMEOUT_CYCLES(100)) dut (
        .clk               (clk),
        .rst               (rst),
        .rxdReady_i        (rxdReady_i),
        .rxdData_i         (rxdData_i),
        .txdBusy_i         (txdBusy_i),
        .txdStart_o        (txdStart_o),
        .txdData_o         (txdData_o),
        .devEnable_o       (devEnable_o),
        .devWrite_o        (devWrite_o),
        .devBusy_i         (devBusy_i),
        .devPhysicalAddr_o (devPhysicalAddr_o),
        .devDataSave_o     (devDataSave_o),
        .devDataLoad_i     (devDataLoad_i),
        .devByteSelect_o   (devByteSelect_o),
        .active_o          (active_o)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  tx_q[$];
    int          tx_viol = 0;
    int          busy_left = 0;
    int          en_cycles = 0;
    int          acc_cnt = 0;
    int          stall_left = 0;
    logic [31:0] cap_addr = 32'h0;
    logic [31:0] cap_data = 32'h0;
    logic        cap_write = 1'b0;

    // Transmitter model: busy for 3 cycles after each start strobe.
    initial forever begin
        @(posedge clk);
        if (txdStart_o === 1'b1) begin
            tx_q.push_back(txdData_o);
            if (txdBusy_i !== 1'b0) tx_viol++;
            busy_left = 3;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        #1;
        txdBusy_i = (busy_left > 0);
    end

    // Device model: stalls stall_left enabled cycles, records each completed access.
    initial forever begin
        @(posedge clk);
        if (devEnable_o === 1'b1) begin
            en_cycles++;
            if (devBusy_i === 1'b0) begin
                acc_cnt++;
                cap_addr  = devPhysicalAddr_o;
                cap_data  = devDataSave_o;
                cap_write = devWrite_o;
            end else if (stall_left > 0) begin
                stall_left--;
            end
        end
        #1;
        devBusy_i = (stall_left > 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rxdData_i  = b;
        rxdReady_i = 1'b1;
        @(negedge clk);
        rxdReady_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (active_o === 1'b0) done = 1'b1;
        end
        check(tag, {31'h0, done}, 32'h1);
    endtask

    task automatic check_tx(input string tag, input int idx, input logic [7:0] exp);
        logic [7:0] v;
        v = (idx < tx_q.size()) ? tx_q[idx] : 8'hxx;
        check(tag, {24'h0, v}, {24'h0, exp});
    endtask

    initial begin
        int acc_before;
        logic seen;

        // Reset state, sampled while rst is still asserted
        #5;
        check("rst_active",   {31'h0, active_o},    32'h0);
        check("rst_enable",   {31'h0, devEnable_o}, 32'h0);
        check("rst_write",    {31'h0, devWrite_o},  32'h0);
        check("rst_txstart",  {31'h0, txdStart_o},  32'h0);
        check("rst_txdata",   {24'h0, txdData_o},   32'h0);
        check("rst_addr",     devPhysicalAddr_o,    32'h0);
        check("rst_wdata",    devDataSave_o,        32'h0);
        check("rst_bytesel",  {28'h0, devByteSelect_o}, 32'hf);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Word write, no stall
        tx_q.delete(); en_cycles = 0; acc_before = acc_cnt;
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        wait_idle("w_idle", 100);
        check("w_acc",     acc_cnt - acc_before, 32'd1);
        check("w_encyc",   en_cycles,            32'd1);
        check("w_addr",    cap_addr,             32'h8000_0000);
        check("w_data",    cap_data,             32'hDEAD_BEEF);
        check("w_wr",      {31'h0, cap_write},   32'h1);
        check("w_txn",     tx_q.size(),          32'd1);
        check_tx("w_tx0", 0, 8'h4B);
        check("w_wr_idle", {31'h0, devWrite_o},  32'h0);

        // Read with 3 stall cycles
        tx_q.delete(); en_cycles = 0; acc_before = acc_cnt;
        devDataLoad_i = 32'h1234_5678;
        stall_left = 3;
        send_byte(8'h52);
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
        wait_idle("r_idle", 200);
        check("r_acc",   acc_cnt - acc_before, 32'd1);
        check("r_encyc", en_cycles,            32'd4);
        check("r_addr",  cap_addr,             32'h8000_0004);
        check("r_wr",    {31'h0, cap_write},   32'h0);
        check("r_txn",   tx_q.size(),          32'd4);
        check_tx("r_tx0", 0, 8'h78);
        check_tx("r_tx1", 1, 8'h56);
        check_tx("r_tx2", 2, 8'h34);
        check_tx("r_tx3", 3, 8'h12);
        check("r_txviol", tx_viol, 32'd0);

        // Bad command byte, then a normal read
        tx_q.delete(); acc_before = acc_cnt;
        devDataLoad_i = 32'hA1B2_C3D4;
        send_byte(8'h41);
        check("bad_active", {31'h0, active_o}, 32'h0);
        repeat (3) @(negedge clk);
        check("bad_acc",    acc_cnt - acc_before, 32'd0);
        check("bad_txn",    tx_q.size(),          32'd0);
        send_byte(8'h52);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_idle("bad_r_idle", 200);
        check("bad_r_addr", cap_addr, 32'h0000_0010);
        check("bad_r_txn",  tx_q.size(), 32'd4);
        check_tx("bad_r_tx0", 0, 8'hD4);
        check_tx("bad_r_tx3", 3, 8'hA1);

        // Timeout after partial write, exactly 100 idle cycles
        tx_q.delete(); acc_before = acc_cnt;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        repeat (99) @(negedge clk);
        check("to_still_active", {31'h0, active_o}, 32'h1);
        @(negedge clk);
        check("to_idle",  {31'h0, active_o}, 32'h0);
        check("to_acc",   acc_cnt - acc_before, 32'd0);
        check("to_txn",   tx_q.size(),          32'd0);
        send_byte(8'h57);
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_idle("to_w_idle", 100);
        check("to_w_acc",  acc_cnt - acc_before, 32'd1);
        check("to_w_data", cap_data, 32'h0403_0201);
        check_tx("to_w_tx0", 0, 8'h4B);

        // Reset during a stalled bus access
        tx_q.delete(); acc_before = acc_cnt;
        stall_left = 1000;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (devEnable_o === 1'b1) seen = 1'b1;
        end
        check("rm_enable_seen", {31'h0, seen}, 32'h1);
        #5;
        rst = 1'b1;
        #1;
        check("rm_enable", {31'h0, devEnable_o}, 32'h0);
        check("rm_active", {31'h0, active_o},    32'h0);
        stall_left = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rm_acc",    acc_cnt - acc_before, 32'd0);
        check("rm_txn",    tx_q.size(),          32'd0);

        // First byte after reset is a command; stray byte during TX is dropped
        tx_q.delete();
        devDataLoad_i = 32'hCAFE_F00D;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (tx_q.size() >= 1) seen = 1'b1;
        end
        check("st_first_tx", {31'h0, seen}, 32'h1);
        repeat (3) @(negedge clk);
        rxdData_i  = 8'h57;
        rxdReady_i = 1'b1;
        @(negedge clk);
        rxdReady_i = 1'b0;
        wait_idle("st_idle", 200);
        check("st_addr", cap_addr, 32'h4000_0000);
        check("st_txn",  tx_q.size(), 32'd4);
        check_tx("st_tx0", 0, 8'h0D);
        check_tx("st_tx1", 1, 8'hF0);
        check_tx("st_tx2", 2, 8'hFE);
        check_tx("st_tx3", 3, 8'hCA);
        repeat (5) @(negedge clk);
        check("st_stay_idle", {31'h0, active_o}, 32'h0);
        check("st_txviol",    tx_viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameter TIMEOUT_CYCLES, default 2500000, SHALL set the maximum number of idle clk cycles allowed between bytes of one command.
REQ-003 Port clk  input  1  system clock, the 25 MHz domain shared with the UART receiver, UART transmitter and device bus.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port rxdReady_i  input  1  one-cycle strobe marking a valid received byte.
REQ-006 Port rxdData_i  input  8  received byte, valid when rxdReady_i=1.
REQ-007 Port txdBusy_i  input  1  UART transmitter busy flag.
REQ-008 Port txdStart_o  output  1  one-cycle transmit request.
REQ-009 Port txdData_o  output  8  byte to transmit, valid when txdStart_o=1.
REQ-010 Port devEnable_o  output  1  device-bus access request.
REQ-011 Port devWrite_o  output  1  1 means write, 0 means read.
REQ-012 Port devBusy_i  input  1  device-bus stall.
REQ-013 Port devPhysicalAddr_o  output  32  bus address.
REQ-014 Port devDataSave_o  output  32  write data.
REQ-015 Port devDataLoad_i  input  32  read data.
REQ-016 Port devByteSelect_o  output  4  byte enables, always 4'hf.
REQ-017 Port active_o  output  1  high whenever the FSM is not in IDLE, so the top level can stall and mux out the CPU.

Function
REQ-018 Command framing SHALL be: one command byte, then 4 address bytes least-significant byte first, then (writes only) 4 data bytes least-significant byte first.
REQ-019 Command byte 0x57 ('W') SHALL select a word write; 0x52 ('R') SHALL select a word read.
REQ-020 Any other command byte SHALL be discarded, and the FSM SHALL remain in IDLE with no bus or TX activity.
REQ-021 The FSM SHALL use exactly the states IDLE, ADDR, DATA, BUS, TX, TXWAIT.
REQ-022 Transitions SHALL be:
  - IDLE->ADDR on a valid command byte.
  - ADDR->DATA after the 4th address byte when the command is W.
  - ADDR->BUS after the 4th address byte when the command is R.
  - DATA->BUS after the 4th data byte.
  - BUS->TX when the access completes.
  - TX->TXWAIT when txdStart_o fires.
  - TXWAIT->TX when more response bytes remain; TXWAIT->IDLE otherwise.
REQ-023 A 2-bit byte counter SHALL count received bytes in ADDR/DATA and sent bytes in TX; it SHALL clear on every state entry and wrap from 3 to 0 when leaving the state.
REQ-024 The FSM SHALL assert devEnable_o on the first BUS cycle and hold it, together with address, data and devWrite_o, stable until the cycle in which devEnable_o=1 and devBusy_i=0, which completes the access.
REQ-025 A bus access SHALL take 1 cycle minimum, plus 1 cycle per stalled cycle; there SHALL be no timeout in BUS.
REQ-026 On read completion, the block SHALL capture devDataLoad_i into the response register in the completing cycle.
REQ-027 devEnable_o SHALL deassert on the cycle after completion.
REQ-028 The read response SHALL be 4 bytes, least-significant byte first; the write response SHALL be the single byte 0x4B ('K'), sent only after write completion.
REQ-029 In TX, txdStart_o SHALL pulse for exactly one cycle, only in a cycle where txdBusy_i=0.
REQ-030 TXWAIT SHALL ignore txdBusy_i in its first cycle and SHALL then wait until txdBusy_i=0 before leaving.
REQ-031 rxdReady_i strobes received in BUS, TX or TXWAIT SHALL be dropped and SHALL NOT be queued.
REQ-032 The timeout counter SHALL run only in ADDR/DATA and SHALL reset on every rxdReady_i; on reaching TIMEOUT_CYCLES it SHALL force IDLE, discard the partial command, and generate no bus access or response.
REQ-033 A byte arriving in the same cycle the timeout is reached SHALL win: the byte is accepted and the counter clears.
REQ-034 Outside BUS, devEnable_o SHALL be 0; devWrite_o SHALL be 0 except in BUS during a W access.

Reset
REQ-035 On rst, outputs SHALL be driven immediately, without waiting for clk:
  - FSM to IDLE;
  - txdStart_o=0, txdData_o=0;
  - devEnable_o=0, devWrite_o=0;
  - devPhysicalAddr_o=0, devDataSave_o=0;
  - active_o=0;
  - counters cleared.
  devByteSelect_o SHALL remain 4'hf.
REQ-036 Reset asserted mid-bus-access SHALL drop devEnable_o immediately, with no completion and no response.
REQ-037 After reset release, the first rxdReady_i SHALL be treated as a command byte.

Verification
REQ-038 Write: bytes 57 00 00 00 80 EF BE AD DE, devBusy_i=0 -> a single-cycle access with devPhysicalAddr_o=0x80000000, devDataSave_o=0xDEADBEEF, devWrite_o=1, then TX sends 0x4B.
REQ-039 Read with stall: bytes 52 04 00 00 80, devBusy_i=1 for 3 cycles, devDataLoad_i=0x12345678 -> devEnable_o held 4 cycles, then TX sends 78 56 34 12 in that order, each txdStart_o issued only when txdBusy_i=0.
REQ-040 Bad command byte 0x41 followed by a valid read -> 0x41 produces no activity, and the read completes normally.
REQ-041 Timeout: TIMEOUT_CYCLES=100, bytes 57 00 00, then silence for 100 cycles -> IDLE, no bus access; a subsequent valid W command succeeds.
REQ-042 Reset mid-access: assert rst during BUS with devBusy_i=1 -> devEnable_o=0 and active_o=0 asynchronously, and no TX follows.
REQ-043 Byte during response: drive rxdReady_i while in TX -> the byte is ignored, the response stream is intact, and the FSM returns to IDLE.
